serial_cmp_sequencer: RTL and testbench
=======================================

Name: serial_cmp_sequencer

Overview:
- Multi-cycle magnitude-comparison controller for one shared 1-bit compare cell.
- Accepts an operand pair through a valid/ready handshake and walks the cell across the bits, MSB first.
- Holds the running greater/equal/less flags in registers and returns a registered one-hot result through a second valid/ready handshake.
- Optional early exit once the first differing bit decides the result; serves narrow-area paths where a full cascaded comparator is too costly.

Parameters:
- WIDTH, 8: operand width in bits; legal values are 2 and above.
- EARLY_EXIT, 1: 1 means finish at the first differing bit; 0 means always examine all WIDTH bits (fixed latency).
- CNT_W, $clog2(WIDTH+1): width of bits_used.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  operand pair offered.
- start_ready  out  1  sequencer can accept; high only in IDLE.
- a  in  WIDTH  operand A; sampled only on the accept edge.
- b  in  WIDTH  operand B; sampled only on the accept edge.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer takes the result.
- gt  out  1  A > B (registered).
- eq  out  1  A == B (registered).
- lt  out  1  A < B (registered).
- bits_used  out  CNT_W  number of bit positions examined for this result.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state = IDLE.
  - start_ready = 1.
  - res_valid = 0.
  - gt = 0, eq = 0, lt = 0.
  - bits_used = 0.
  - idx, a_q, b_q = 0.
- States: IDLE, RUN, DONE. start_ready = (state==IDLE); res_valid = (state==DONE).
- IDLE:
  - On start_valid & start_ready: latch a_q=a, b_q=b; idx=WIDTH-1; run flags gt=0, eq=1, lt=0; bits_used=0; go to RUN.
  - Otherwise hold.
- RUN (one bit per cycle). The compare cell evaluates a_q[idx] and b_q[idx] against the current flags:
  - If eq=1 and a_q[idx]>b_q[idx]: gt=1, eq=0.
  - If eq=1 and a_q[idx]<b_q[idx]: lt=1, eq=0.
  - Otherwise the flags are unchanged.
  - bits_used increments each RUN cycle.
  - Go to DONE when idx==0, or when EARLY_EXIT=1 and the cell just cleared eq. Otherwise idx decrements.
- DONE:
  - Flags and bits_used are frozen and stable while res_valid=1.
  - On res_ready: go to IDLE. Flags keep their values until the next accept.
- Latency:
  - Let k = number of bits examined. k = WIDTH when EARLY_EXIT=0 or the operands are equal. Otherwise k = WIDTH - p, where p is the highest differing bit index.
  - res_valid rises on the k-th rising edge after the accept edge.
- One-hot invariant: exactly one of gt/eq/lt is 1 in RUN and DONE.
- Back-to-back operation: start_ready=0 in DONE, so a new start is accepted no earlier than the cycle after the result handshake (no overlap). start_valid during RUN/DONE is ignored, not queued.
- Changes on a/b outside the accept edge have no effect.
- res_ready while not in DONE is ignored.
- rst asserted mid-RUN or mid-DONE: the operation is abandoned with no result and all outputs return to reset values immediately.
- idx never wraps: the RUN exit at idx==0 precedes the decrement.

Decomposition:
- Shared constants include file holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - flag bit positions (GT=2, EQ=1, LT=0) for the 3-bit flag bus.
- One sub-module, cmp_bit_cell: combinational.
  - Inputs: a_bit, b_bit, gt_in, eq_in, lt_in.
  - Outputs: gt_out, eq_out, lt_out, MSB-first priority as described above.
  - The sequencer holds exactly one instance.
- FSM, index counter and flag registers live in the top module.

Test Plan:
1. WIDTH=8, EARLY_EXIT=0, a=0xA5, b=0xA5 -> res_valid on the 8th edge after accept; eq=1, gt=0, lt=0; bits_used=8.
2. EARLY_EXIT=1, a=0x80, b=0x7F -> res_valid on the 1st edge after accept; gt=1; bits_used=1.
3. EARLY_EXIT=1, a=0x12, b=0x13 -> lt=1, bits_used=8, 8-cycle latency. Repeat with EARLY_EXIT=0, a=0x80, b=0x7F -> gt=1, bits_used=8.
4. Result back-pressure: hold res_ready=0 for 5 cycles after res_valid and toggle a/b and start_valid meanwhile -> outputs and bits_used unchanged; start_ready=0. Then res_ready=1 -> IDLE next edge; start_ready=1.
5. Pulse rst for one cycle during RUN of a=0x0F, b=0xF0, asynchronously between edges -> outputs go to reset values immediately, no res_valid. A following start with a=0x03, b=0x01 -> gt=1, bits_used=7.
6. Random soak: 1000 random pairs with random valid/ready stalls, under both EARLY_EXIT settings -> gt/eq/lt match A>B / A==B / A<B; one-hot holds every cycle; bits_used matches the latency formula.

Source files
------------

// File: rtl/serial_cmp_sequencer_pkg.sv
// Shared state encodings and flag-bus bit positions for the serial comparator.
// Flags travel as a 3-bit bus {gt, eq, lt}.
package serial_cmp_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_GT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 0;

    localparam logic [2:0] FLAGS_CLEAR = 3'b000;
    localparam logic [2:0] FLAGS_START = 3'b010;

endpackage

// File: rtl/serial_cmp_sequencer_cmp_bit_cell.sv
// One-bit magnitude compare cell, combinational, MSB-first priority:
// only an undecided (eq) comparison can be resolved by the current bit.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_out,
    output logic eq_out,
    output logic lt_out
);

    always_comb begin
        gt_out = gt_in;
        eq_out = eq_in;
        lt_out = lt_in;
        if (eq_in && a_bit && !b_bit) begin
            gt_out = 1'b1;
            eq_out = 1'b0;
        end else if (eq_in && !a_bit && b_bit) begin
            lt_out = 1'b1;
            eq_out = 1'b0;
        end
    end

endmodule

// File: rtl/serial_cmp_sequencer.sv
// Serial magnitude comparator: one bit per cycle MSB first, k cycles from accept to
// res_valid; start_ready only in IDLE, result held in DONE until res_ready.
module serial_cmp_sequencer
    import serial_cmp_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CNT_W-1:0] bits_used
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_flags;
    logic [CNT_W-1:0] r_bits_used;

    logic [2:0]       w_cell_flags;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_decided;
    logic             w_run_exit;

    cmp_bit_cell u_cell (
        .a_bit  (r_a[r_idx]),
        .b_bit  (r_b[r_idx]),
        .gt_in  (r_flags[FLAG_GT]),
        .eq_in  (r_flags[FLAG_EQ]),
        .lt_in  (r_flags[FLAG_LT]),
        .gt_out (w_cell_flags[FLAG_GT]),
        .eq_out (w_cell_flags[FLAG_EQ]),
        .lt_out (w_cell_flags[FLAG_LT])
    );

    assign w_accept   = (r_state == ST_IDLE) && start_valid;
    assign w_last_bit = (r_idx == '0);
    // The cell clearing eq means this bit decided the outcome.
    assign w_decided  = r_flags[FLAG_EQ] && !w_cell_flags[FLAG_EQ];
    assign w_run_exit = w_last_bit || ((EARLY_EXIT != 0) && w_decided);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_valid) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_run_exit)  w_state_nxt = ST_DONE;
            ST_DONE: if (res_ready)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_flags     <= FLAGS_CLEAR;
            r_bits_used <= '0;
        end else if (w_accept) begin
            r_idx       <= IDX_W'(WIDTH - 1);
            r_a         <= a;
            r_b         <= b;
            r_flags     <= FLAGS_START;
            r_bits_used <= '0;
        end else if (r_state == ST_RUN) begin
            r_flags     <= w_cell_flags;
            r_bits_used <= r_bits_used + CNT_W'(1);
            // Exit at idx 0 takes precedence so the index never wraps.
            if (!w_run_exit) begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign gt          = r_flags[FLAG_GT];
    assign eq          = r_flags[FLAG_EQ];
    assign lt          = r_flags[FLAG_LT];
    assign bits_used   = r_bits_used;

endmodule

// File: tb/tb_serial_cmp_sequencer.sv
// Drives two sequencers (fixed latency and early exit) and compares against a
// reference computed from integer comparison and the highest differing bit.
module tb_serial_cmp_sequencer;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    sv, sr, rv, rr, gt, eq, lt;
    logic [W-1:0]  a_in [2];
    logic [W-1:0]  b_in [2];
    logic [CW-1:0] bu   [2];

    int checks = 0;
    int errors = 0;

    serial_cmp_sequencer #(.WIDTH(W), .EARLY_EXIT(0)) u_dut_fix (
        .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
        .a(a_in[0]), .b(b_in[0]), .res_valid(rv[0]), .res_ready(rr[0]),
        .gt(gt[0]), .eq(eq[0]), .lt(lt[0]), .bits_used(bu[0])
    );

    serial_cmp_sequencer #(.WIDTH(W), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
        .a(a_in[1]), .b(b_in[1]), .res_valid(rv[1]), .res_ready(rr[1]),
        .gt(gt[1]), .eq(eq[1]), .lt(lt[1]), .bits_used(bu[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y);
        int ix = int'(x);
        int iy = int'(y);
        return {ix > iy, ix == iy, ix < iy};
    endfunction

    // Bits examined: all W unless early exit and a difference exists, then W - p.
    function automatic int ref_bits(input int d, input logic [W-1:0] x, input logic [W-1:0] y);
        int diff = int'(x) ^ int'(y);
        int p = -1;
        for (int i = 0; i < W; i++) begin
            if (diff >= (1 << i)) p = i;
        end
        if (d == 0 || p < 0) return W;
        return W - p;
    endfunction

    task automatic run_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int pre, input int hold);
        logic [2:0] ef;
        int         ek;
        int         n;
        ef = ref_flags(x, y);
        ek = ref_bits(d, x, y);
        sv[d] = 1'b0;
        repeat (pre) begin
            a_in[d] = W'($urandom);
            b_in[d] = W'($urandom);
            @(posedge clk); #1;
        end
        check("idle_start_ready", 32'(sr[d]), 32'd1);
        a_in[d] = x;
        b_in[d] = y;
        sv[d]   = 1'b1;
        @(posedge clk); #1;
        a_in[d] = ~x;
        b_in[d] = W'($urandom);
        n = 0;
        while (!rv[d] && n < W + 4) begin
            check("onehot_run", 32'($countones({gt[d], eq[d], lt[d]})), 32'd1);
            check("run_start_ready", 32'(sr[d]), 32'd0);
            sv[d]   = 1'($urandom_range(0, 1));
            rr[d]   = 1'($urandom_range(0, 1));
            a_in[d] = W'($urandom);
            @(posedge clk); #1;
            n++;
        end
        rr[d] = 1'b0;
        check("latency", 32'(n), 32'(ek));
        check("flags", 32'({gt[d], eq[d], lt[d]}), 32'(ef));
        check("bits_used", 32'(bu[d]), 32'(ek));
        repeat (hold) begin
            sv[d]   = 1'($urandom_range(0, 1));
            a_in[d] = W'($urandom);
            b_in[d] = W'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(rv[d]), 32'd1);
            check("hold_start_ready", 32'(sr[d]), 32'd0);
            check("hold_flags", 32'({gt[d], eq[d], lt[d]}), 32'(ef));
            check("hold_bits", 32'(bu[d]), 32'(ek));
        end
        sv[d] = 1'b0;
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
        check("post_valid", 32'(rv[d]), 32'd0);
        check("post_start_ready", 32'(sr[d]), 32'd1);
        check("post_flags", 32'({gt[d], eq[d], lt[d]}), 32'(ef));
    endtask

    task automatic check_reset(input int d);
        check("rst_start_ready", 32'(sr[d]), 32'd1);
        check("rst_valid", 32'(rv[d]), 32'd0);
        check("rst_flags", 32'({gt[d], eq[d], lt[d]}), 32'd0);
        check("rst_bits", 32'(bu[d]), 32'd0);
    endtask

    initial begin
        logic [W-1:0] x, y;
        rst = 1'b1;
        sv  = '0;
        rr  = '0;
        for (int d = 0; d < 2; d++) begin
            a_in[d] = '0;
            b_in[d] = '0;
        end
        #2;
        check_reset(0);
        check_reset(1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 8'hA5, 8'hA5, 0, 1);
        run_op(1, 8'h80, 8'h7F, 0, 1);
        run_op(1, 8'h12, 8'h13, 1, 0);
        run_op(0, 8'h80, 8'h7F, 0, 5);
        run_op(1, 8'hA5, 8'hA5, 0, 5);

        a_in[0] = 8'h0F;
        b_in[0] = 8'hF0;
        sv[0]   = 1'b1;
        @(posedge clk); #1;
        sv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset(0);
        #1 rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("no_res_after_rst", 32'(rv[0]), 32'd0);
        end
        run_op(1, 8'h03, 8'h01, 0, 1);
        run_op(0, 8'h03, 8'h01, 0, 1);

        for (int it = 0; it < 1000; it++) begin
            for (int d = 0; d < 2; d++) begin
                x = W'($urandom);
                case ($urandom_range(0, 3))
                    0:       y = x;
                    1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
                    default: y = W'($urandom);
                endcase
                run_op(d, x, y, $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
